// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO family: width math and read-mode constants.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int fifo_clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    // Pointers wrap naturally; the count needs one extra bit to represent DEPTH itself.
    function automatic int fifo_ptr_w(input int depth);
        return fifo_clog2(depth);
    endfunction

    function automatic int fifo_cnt_w(input int depth);
        return fifo_clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port, no reset.
module sync_fifo_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) mem_q[i_waddr] <= i_wdata;
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with optional first-word-fall-through, almost-full/empty thresholds,
// occupancy count and sticky overflow/underflow flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 16,
    parameter int FWFT      = FIFO_STD,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_wr,
    input  logic [DATA_W-1:0]           i_wdata,
    output logic                        o_full,
    output logic                        o_afull,
    input  logic                        i_rd,
    output logic [DATA_W-1:0]           o_rdata,
    output logic                        o_rvalid,
    output logic                        o_empty,
    output logic                        o_aempty,
    output logic [fifo_cnt_w(DEPTH)-1:0] o_count,
    output logic                        o_ovf,
    output logic                        o_udf,
    input  logic                        i_clr_err
);

    localparam int PW = fifo_ptr_w(DEPTH);
    localparam int CW = fifo_cnt_w(DEPTH);

    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] mem_rdata;

    // Flags decode only the registered count, so they move on the edge after the event.
    assign o_full   = (count_q == CW'(DEPTH));
    assign o_empty  = (count_q == '0);
    assign o_afull  = (count_q >= CW'(AF_THRESH));
    assign o_aempty = (count_q <= CW'(AE_THRESH));
    assign o_count  = count_q;
    assign o_ovf    = ovf_q;
    assign o_udf    = udf_q;

    assign wr_acc = i_wr & ~o_full;
    assign rd_acc = i_rd & ~o_empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_acc) wptr_d = wptr_q + PW'(1);
        if (rd_acc) rptr_d = rptr_q + PW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A new error in the same cycle as a clear must survive.
        ovf_d = (ovf_q & ~i_clr_err) | (i_wr & o_full);
        udf_d = (udf_q & ~i_clr_err) | (i_rd & o_empty);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (wr_acc),
        .i_waddr (wptr_q),
        .i_wdata (i_wdata),
        .i_raddr (rptr_q),
        .o_rdata (mem_rdata)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            assign o_rdata  = o_empty ? '0 : mem_rdata;
            assign o_rvalid = ~o_empty;
        end else begin : g_std
            logic [DATA_W-1:0] rdata_q, rdata_d;
            logic              rvalid_q, rvalid_d;

            always_comb begin
                rdata_d  = rdata_q;
                rvalid_d = 1'b0;
                if (rd_acc) begin
                    rdata_d  = mem_rdata;
                    rvalid_d = 1'b1;
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign o_rdata  = rdata_q;
            assign o_rvalid = rvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives one stimulus stream into a standard-mode and an FWFT-mode FIFO and checks
// both against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int DW = 16;
    localparam int DP = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr = 1'b0, rd = 1'b0, clr = 1'b0;
    logic [DW-1:0] wdata = '0;

    logic          s_full, s_afull, s_empty, s_aempty, s_rvalid, s_ovf, s_udf;
    logic [DW-1:0] s_rdata;
    logic [3:0]    s_count;
    logic          f_full, f_afull, f_empty, f_aempty, f_rvalid, f_ovf, f_udf;
    logic [DW-1:0] f_rdata;
    logic [3:0]    f_count;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
        .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_wdata(wdata),
        .o_full(s_full), .o_afull(s_afull), .i_rd(rd), .o_rdata(s_rdata),
        .o_rvalid(s_rvalid), .o_empty(s_empty), .o_aempty(s_aempty), .o_count(s_count),
        .o_ovf(s_ovf), .o_udf(s_udf), .i_clr_err(clr)
    );

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
        .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_wdata(wdata),
        .o_full(f_full), .o_afull(f_afull), .i_rd(rd), .o_rdata(f_rdata),
        .o_rvalid(f_rvalid), .o_empty(f_empty), .o_aempty(f_aempty), .o_count(f_count),
        .o_ovf(f_ovf), .o_udf(f_udf), .i_clr_err(clr)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [DW-1:0] sb_q[$];
    int          m_cnt = 0;
    logic        m_ovf = 1'b0, m_udf = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    int          max_cnt = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic chk_all(input logic racc);
        chk("count",   s_count,  m_cnt);
        chk("empty",   s_empty,  m_cnt == 0);
        chk("full",    s_full,   m_cnt == DP);
        chk("afull",   s_afull,  m_cnt >= AF);
        chk("aempty",  s_aempty, m_cnt <= AE);
        chk("ovf",     s_ovf,    m_ovf);
        chk("udf",     s_udf,    m_udf);
        chk("rvalid",  s_rvalid, racc);
        chk("rdata",   s_rdata,  m_rdata);
        chk("f_count", f_count,  m_cnt);
        chk("f_ovf",   f_ovf,    m_ovf);
        chk("f_udf",   f_udf,    m_udf);
        chk("f_rvalid", f_rvalid, m_cnt != 0);
        chk("f_rdata", f_rdata,  (m_cnt != 0) ? sb_q[0] : '0);
    endtask

    // One clock of traffic: model acceptance uses the pre-edge occupancy.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
        logic wacc, racc;
        wr = w; rd = r; wdata = d; clr = c;
        wacc = w && (m_cnt != DP);
        racc = r && (m_cnt != 0);
        m_ovf = (m_ovf & ~c) | (w && m_cnt == DP);
        m_udf = (m_udf & ~c) | (r && m_cnt == 0);
        @(posedge clk);
        #1;
        if (racc) m_rdata = sb_q.pop_front();
        if (wacc) sb_q.push_back(d);
        m_cnt = m_cnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
        if (m_cnt > max_cnt) max_cnt = m_cnt;
        wr = 1'b0; rd = 1'b0; clr = 1'b0;
        chk_all(racc);
    endtask

    task automatic do_reset(input logic w);
        rst = 1'b1; wr = w; rd = w; wdata = 16'hbeef;
        @(posedge clk);
        #1;
        rst = 1'b0; wr = 1'b0; rd = 1'b0;
        sb_q.delete();
        m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0; m_rdata = '0;
        chk_all(1'b0);
    endtask

    initial begin
        logic [DW-1:0] pat [6];
        pat = '{16'd10, 16'd96, 16'd23, 16'd100, 16'd69, 16'd37};

        do_reset(1'b0);

        // Reset in the middle of traffic discards everything.
        step(1, 0, 16'd5, 0);
        step(1, 0, 16'd6, 0);
        do_reset(1'b1);

        foreach (pat[i]) step(1, 0, pat[i], 0);
        for (int i = 0; i < 6; i++) step(0, 1, '0, 0);

        // Fill past full: ninth write rejected.
        for (int i = 0; i < 9; i++) step(1, 0, DW'(i), 0);
        // Read + write at full: pop only.
        step(1, 1, 16'd55, 0);
        step(1, 0, 16'd77, 0);
        // Clear collides with a fresh overflow: overflow stays.
        step(1, 0, 16'd88, 1);
        step(0, 0, '0, 1);
        for (int i = 0; i < 8; i++) step(0, 1, '0, 0);

        // Read + write at empty: write only, underflow set.
        step(1, 1, 16'd42, 0);
        step(0, 1, '0, 0);
        step(0, 0, '0, 1);

        // FWFT walkthrough (both DUTs see it; the FWFT view is checked each step).
        step(1, 0, 16'd7, 0);
        step(0, 0, '0, 0);
        step(1, 0, 16'd8, 0);
        step(0, 1, '0, 0);
        step(0, 1, '0, 0);
        step(0, 0, '0, 0);

        // Pointer wrap with single-entry occupancy.
        max_cnt = 0;
        for (int i = 0; i < 3 * DP; i++) begin
            step(1, 0, DW'(16'h100 + i), 0);
            step(0, 1, '0, 0);
        end
        chk("wrap_max_count", max_cnt, 1);

        // Random mixed traffic including error clears.
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 DW'($urandom), 1'($urandom_range(0, 7) == 0));

        do_reset(1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised successor to the dual-clock aFIFO.
- Serves buffering paths where producer and consumer share one clock.
- Configurable data width and depth.
- Adds a first-word-fall-through (FWFT) mode, programmable almost-full and almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags.

Parameters:
- DATA_W, 16: data word width in bits.
- DEPTH, 16: number of entries. Must be a power of 2 and at least 4.
- FWFT, 0: read mode. 0 = standard registered read; 1 = first-word-fall-through.
- AF_THRESH, DEPTH-2: o_afull asserts when count >= AF_THRESH. Legal range 1..DEPTH.
- AE_THRESH, 2: o_aempty asserts when count <= AE_THRESH. Legal range 0..DEPTH-1.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_wr  in  1  write request.
- i_wdata  in  DATA_W  write data.
- o_full  out  1  count == DEPTH.
- o_afull  out  1  count >= AF_THRESH.
- i_rd  in  1  read (pop) request.
- o_rdata  out  DATA_W  read data.
- o_rvalid  out  1  o_rdata is valid (meaning depends on mode).
- o_empty  out  1  count == 0.
- o_aempty  out  1  count <= AE_THRESH.
- o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_ovf  out  1  sticky: a write was attempted while full.
- o_udf  out  1  sticky: a read was attempted while empty.
- i_clr_err  in  1  clears o_ovf and o_udf.

Behaviour:
- Reset (i_rst=1 at the edge):
  - wptr=0, rptr=0, count=0.
  - o_empty=1, o_aempty=1, o_full=0, o_afull=0.
  - o_rdata=0, o_rvalid=0, o_ovf=0, o_udf=0.
  - Memory contents are not reset.
  - Reset overrides every other input in the same cycle, including mid-burst traffic.
- Accept rules, evaluated on pre-edge flags:
  - wr_acc = i_wr & ~o_full.
  - rd_acc = i_rd & ~o_empty.
  - A write while full is rejected, even if a read is accepted in the same cycle.
  - A read while empty is rejected, even if a write is accepted in the same cycle.
- Pointers:
  - On wr_acc: mem[wptr] <= i_wdata; wptr increments mod DEPTH.
  - On rd_acc: rptr increments mod DEPTH.
  - Pointers are $clog2(DEPTH) bits wide and wrap naturally.
- Count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- Flags:
  - All flags are combinational decodes of the count register only, so they change on the edge after the accepting event.
- Standard mode (FWFT=0):
  - On rd_acc, o_rdata <= mem[rptr] and o_rvalid <= 1 (1-cycle read latency).
  - Otherwise o_rvalid <= 0 and o_rdata holds its value.
- FWFT mode (FWFT=1):
  - o_rdata = mem[rptr] when ~o_empty, else 0.
  - o_rvalid = ~o_empty.
  - i_rd acknowledges (pops) the word currently shown.
  - Latency from the first write into an empty FIFO to o_rvalid=1 is 1 cycle.
- Read/write interaction when empty: a simultaneous read+write accepts the write only, sets o_udf, and leaves count=1.
- Read/write interaction when full: a simultaneous read+write accepts the read only, sets o_ovf, and leaves count=DEPTH-1.
- Error flags:
  - o_ovf sets on i_wr & o_full; o_udf sets on i_rd & o_empty.
  - i_clr_err clears both.
  - If a set condition and i_clr_err occur in the same cycle, the set wins.
- Rejected operations never modify memory, pointers, count or o_rdata.

Decomposition:
- fifo_pkg holds:
  - a clog2 helper function;
  - pointer-width and count-width localparam expressions;
  - mode constants FIFO_STD=0 and FIFO_FWFT=1.
- One sub-module, sync_fifo_mem:
  - DEPTH x DATA_W dual-port array;
  - synchronous write;
  - asynchronous read port;
  - the top level adds the output register in standard mode.
- Pointer, count and flag logic stays in the top level.

Test Plan:
- Reset and basic order (DEPTH=8, FWFT=0): assert i_rst mid-stream, then write 10, 96, 23, 100, 69, 37 and read 6 times → o_rdata sequence 10, 96, 23, 100, 69, 37, each one cycle after its rd_acc, and o_count returns to 0 with o_empty=1.
- Fill and overflow (DEPTH=8, AF_THRESH=6): write 9 words 0..8 → o_afull rises after the 6th write, o_full rises after the 8th, the 9th write is rejected, o_ovf=1, and reading back yields 0..7 only.
- Simultaneous read and write at full: issue i_wr=i_rd=1 with data 55 → one word popped, write rejected, o_count=7, o_ovf=1; then assert i_clr_err together with another i_wr while full → o_ovf stays 1 (set wins).
- Underflow and empty corner: from empty, drive i_rd=i_wr=1 with data 42 → o_count=1, o_udf=1, o_rvalid=0; next read returns 42.
- FWFT mode (FWFT=1): write 7 → o_rvalid=1 and o_rdata=7 on the following cycle with no i_rd; write 8, pop → o_rdata=8; pop again → o_empty=1 and o_rdata=0.
- Pointer wrap: run 3×DEPTH interleaved write/read pairs of an incrementing pattern → no data mismatch, o_count never exceeds 1, and o_aempty stays 1 with AE_THRESH=2.
